// File: rtl/core_execution_unit_div.sv
// rtl/core_execution_unit_div.sv - radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow retire without iterating.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module core_execution_unit_div #(
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] s1_i,
    input  logic [DATA_WIDTH-1:0] s2_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] s1_q, s1_d;
    logic                  qneg_q, qneg_d;
    logic                  rneg_q, rneg_d;
    logic                  div0_q, div0_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    logic                  in_signed, in_s1_neg, in_s2_neg, in_div0, in_ovf;
    logic [DATA_WIDTH:0]   shifted, trial;
    logic [DATA_WIDTH-1:0] rem_nx, quo_nx, q_fin, r_fin, calc_res;

    // Value RISC-V mandates for the two exceptional cases; op[1] selects remainder.
    function automatic logic [DATA_WIDTH-1:0] special_value(
        input logic [1:0]            op,
        input logic [DATA_WIDTH-1:0] dividend,
        input logic                  div0
    );
        if (div0)
            special_value = op[1] ? dividend : '1;
        else
            special_value = op[1] ? '0 : dividend;
    endfunction

    always_comb begin
        in_signed = ~op_i[0];
        in_s1_neg = in_signed & s1_i[DATA_WIDTH-1];
        in_s2_neg = in_signed & s2_i[DATA_WIDTH-1];
        in_div0   = (s2_i == '0);
        in_ovf    = in_signed && (s1_i == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (s2_i == '1);

        shifted = {rem_q, quo_q[DATA_WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        rem_nx  = trial[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
        quo_nx  = {quo_q[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
        q_fin   = qneg_q ? -quo_nx : quo_nx;
        r_fin   = rneg_q ? -rem_nx : rem_nx;
        if (div0_q || ovf_q)
            calc_res = special_value(op_q, s1_q, div0_q);
        else
            calc_res = op_q[1] ? r_fin : q_fin;

        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        s1_d     = s1_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        result_d = result_q;

        case (state_q)
            S_CALC: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    result_d = calc_res;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (start_i) begin
                    state_d = S_CALC;
                    op_d    = op_i;
                    s1_d    = s1_i;
                    quo_d   = in_s1_neg ? -s1_i : s1_i;
                    dvs_d   = in_s2_neg ? -s2_i : s2_i;
                    rem_d   = '0;
                    cnt_d   = '0;
                    qneg_d  = in_s1_neg ^ in_s2_neg;
                    rneg_d  = in_s1_neg;
                    div0_d  = in_div0;
                    ovf_d   = in_ovf;
`ifdef DIV_FAST_SPECIAL_EN
                    if (in_div0 || in_ovf) begin
                        state_d  = S_DONE;
                        result_d = special_value(op_i, s1_i, in_div0);
                    end
`endif
                end
            end
        endcase

        // Abort discards the operation but leaves the last result visible.
        if (flush_i) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            s1_q     <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            s1_q     <= s1_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q == S_CALC);
    assign valid_o  = (state_q == S_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_core_execution_unit_div.sv
// tb/tb_core_execution_unit_div.sv - directed self-checking bench for core_execution_unit_div
module tb_core_execution_unit_div;

    localparam int W = 32;
    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
`ifdef DIV_FAST_SPECIAL_EN
    localparam int SPEC_LAT  = 1;
    localparam int SPEC_BUSY = 0;
`else
    localparam int SPEC_LAT  = 33;
    localparam int SPEC_BUSY = 32;
`endif

    logic         clk_i = 1'b0;
    logic         rstn_i = 1'b0;
    logic         start_i = 1'b0;
    logic [1:0]   op_i = 2'b00;
    logic [W-1:0] s1_i = '0;
    logic [W-1:0] s2_i = '0;
    logic         flush_i = 1'b0;
    logic         busy_o;
    logic         valid_o;
    logic [W-1:0] result_o;

    int checks = 0;
    int errors = 0;

    core_execution_unit_div #(.DATA_WIDTH(W)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .op_i(op_i),
        .s1_i(s1_i), .s2_i(s2_i), .flush_i(flush_i),
        .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;

    // Called at the first falling edge after the start edge; counts that edge as 1.
    task automatic wait_done(output logic [W-1:0] res, output int lat, output int busy_cnt,
                             output bit overlap);
        res = '0; lat = -1; busy_cnt = 0; overlap = 0;
        for (int i = 1; i <= 100; i++) begin
            if (busy_o && valid_o) overlap = 1;
            if (valid_o) begin
                lat = i;
                res = result_o;
                break;
            end
            if (busy_o) busy_cnt++;
            @(negedge clk_i);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output int lat, output int busy_cnt,
                          output bit overlap);
        @(negedge clk_i);
        start_i = 1'b1; op_i = op; s1_i = a; s2_i = b;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done(res, lat, busy_cnt, overlap);
    endtask

    task automatic test_reset;
        rstn_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
        checks++; if (result_o !== '0) begin errors++; $display("FAIL reset_result got %h want 0", result_o); end
        rstn_i = 1'b1;
    endtask

    task automatic test_unsigned;
        logic [W-1:0] r; int lat, bc; bit ov;
        run_op(OP_DIVU, 32'd100, 32'd7, r, lat, bc, ov);
        checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu_100_7 got %h want %h", r, 32'd14); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL divu_latency got %0d want 33", lat); end
        checks++; if (bc !== 32) begin errors++; $display("FAIL divu_busy_cycles got %0d want 32", bc); end
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL busy_valid_overlap got %b want 0", ov); end
        run_op(OP_REMU, 32'd100, 32'd7, r, lat, bc, ov);
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu_100_7 got %h want %h", r, 32'd2); end
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd16, r, lat, bc, ov);
        checks++; if (r !== 32'h0FFF_FFFF) begin errors++; $display("FAIL divu_max_16 got %h want 0fffffff", r); end
    endtask

    task automatic test_signed;
        logic [W-1:0] r; int lat, bc; bit ov;
        run_op(OP_DIV, -32'sd7, 32'd2, r, lat, bc, ov);
        checks++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2 got %h want fffffffd", r); end
        run_op(OP_REM, -32'sd7, 32'd2, r, lat, bc, ov);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_m7_2 got %h want ffffffff", r); end
        run_op(OP_REM, 32'd7, -32'sd2, r, lat, bc, ov);
        checks++; if (r !== 32'd1) begin errors++; $display("FAIL rem_7_m2 got %h want 00000001", r); end
        run_op(OP_DIV, 32'd7, -32'sd2, r, lat, bc, ov);
        checks++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_7_m2 got %h want fffffffd", r); end
        run_op(OP_DIV, -32'sd20, -32'sd6, r, lat, bc, ov);
        checks++; if (r !== 32'd3) begin errors++; $display("FAIL div_m20_m6 got %h want 00000003", r); end
    endtask

    task automatic test_special;
        logic [W-1:0] r; int lat, bc; bit ov;
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc, ov);
        checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL div_overflow got %h want 80000000", r); end
        checks++; if (lat !== SPEC_LAT) begin errors++; $display("FAIL ovf_latency got %0d want %0d", lat, SPEC_LAT); end
        checks++; if (bc !== SPEC_BUSY) begin errors++; $display("FAIL ovf_busy_cycles got %0d want %0d", bc, SPEC_BUSY); end
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc, ov);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL rem_overflow got %h want 00000000", r); end
        run_op(OP_DIVU, 32'd5, 32'd0, r, lat, bc, ov);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_by_zero got %h want ffffffff", r); end
        checks++; if (lat !== SPEC_LAT) begin errors++; $display("FAIL div0_latency got %0d want %0d", lat, SPEC_LAT); end
        run_op(OP_REM, 32'd5, 32'd0, r, lat, bc, ov);
        checks++; if (r !== 32'd5) begin errors++; $display("FAIL rem_by_zero got %h want 00000005", r); end
        run_op(OP_DIV, -32'sd5, 32'd0, r, lat, bc, ov);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_by_zero got %h want ffffffff", r); end
        run_op(OP_REM, -32'sd5, 32'd0, r, lat, bc, ov);
        checks++; if (r !== 32'hFFFF_FFFB) begin errors++; $display("FAIL rem_neg_by_zero got %h want fffffffb", r); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] r; int lat, bc; bit ov;
        run_op(OP_DIVU, 32'd9, 32'd3, r, lat, bc, ov);
        checks++; if (r !== 32'd3) begin errors++; $display("FAIL b2b_first got %h want 00000003", r); end
        start_i = 1'b1; op_i = OP_REMU; s1_i = 32'd9; s2_i = 32'd4;
        @(negedge clk_i);
        start_i = 1'b0;
        checks++; if (busy_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++; $display("FAIL b2b_reenter got busy=%b valid=%b want busy=1 valid=0", busy_o, valid_o);
        end
        wait_done(r, lat, bc, ov);
        checks++; if (r !== 32'd1) begin errors++; $display("FAIL b2b_second got %h want 00000001", r); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", lat); end
    endtask

    task automatic test_flush;
        logic [W-1:0] r; int lat, bc; bit ov; int extra;
        run_op(OP_DIVU, 32'd50, 32'd5, r, lat, bc, ov);
        @(negedge clk_i);
        start_i = 1'b1; op_i = OP_DIVU; s1_i = 32'd1000; s2_i = 32'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++; $display("FAIL flush_state got busy=%b valid=%b want 0 0", busy_o, valid_o);
        end
        checks++; if (result_o !== 32'd10) begin errors++; $display("FAIL flush_result_kept got %h want 0000000a", result_o); end
        extra = 0;
        repeat (40) begin @(negedge clk_i); if (valid_o) extra++; end
        checks++; if (extra !== 0) begin errors++; $display("FAIL flush_no_valid got %0d pulses want 0", extra); end
        run_op(OP_DIVU, 32'd1000, 32'd3, r, lat, bc, ov);
        checks++; if (r !== 32'd333) begin errors++; $display("FAIL after_flush got %h want 0000014d", r); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk_i);
        start_i = 1'b1; op_i = OP_DIVU; s1_i = 32'd100; s2_i = 32'd7;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        #2 rstn_i = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== '0) begin
            errors++; $display("FAIL async_reset got busy=%b valid=%b result=%h want 0 0 0", busy_o, valid_o, result_o);
        end
        @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    task automatic test_start_ignored;
        logic [W-1:0] r; int lat, bc; bit ov; int extra;
        @(negedge clk_i);
        start_i = 1'b1; op_i = OP_DIVU; s1_i = 32'd100; s2_i = 32'd7;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        start_i = 1'b1; op_i = OP_REMU; s1_i = 32'd9; s2_i = 32'd4;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done(r, lat, bc, ov);
        checks++; if (r !== 32'd14) begin errors++; $display("FAIL ignore_start_result got %h want 0000000e", r); end
        checks++; if (lat !== 28) begin errors++; $display("FAIL ignore_start_latency got %0d want 28", lat); end
        extra = 0;
        repeat (40) begin @(negedge clk_i); if (valid_o) extra++; end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_start_extra got %0d pulses want 0", extra); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_execution_unit_div.md
# core_execution_unit_div

Multi-cycle integer divide unit for the RV32M DIV/DIVU/REM/REMU instructions, sitting beside the single-cycle ALU in the execution unit. The ALU covers add/sub/shift/compare in one cycle. This block does the inverse of multiplication with a radix-2 restoring iteration, one quotient bit per clock. The execution unit starts it with a one-cycle strobe, stalls on `busy_o`, and takes the result when `valid_o` pulses.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32): operand and result width.

Ports:
- `clk_i`  in  1  clock; all state changes on its rising edge.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  strobe that launches an operation; sampled only in IDLE or DONE.
- `op_i`  in  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with `start_i`.
- `s1_i`  in  DATA_WIDTH  dividend; sampled with `start_i`.
- `s2_i`  in  DATA_WIDTH  divisor; sampled with `start_i`.
- `flush_i`  in  1  abort; takes priority over everything except reset.
- `busy_o`  out  1  high while in CALC.
- `valid_o`  out  1  one-cycle pulse, high while in DONE.
- `result_o`  out  DATA_WIDTH  quotient or remainder; holds its value until the next DONE.

## Operation
States:
- IDLE
- CALC: iteration counter runs 0..DATA_WIDTH-1.
- DONE: lasts exactly one cycle.

Transitions:
- IDLE/DONE with `start_i`=1 → CALC. Latch op, operand magnitudes and sign flags; clear the partial remainder; counter = 0.
- IDLE/DONE with `start_i`=0 → IDLE.
- CALC, counter = DATA_WIDTH-1 → DONE, with the final result written into `result_o`.
- `start_i` during CALC is ignored. It is not queued.
- `flush_i`=1 in any state → IDLE at the next edge. No `valid_o` is produced, and `result_o` is unchanged.

Arithmetic:
- Signed ops (DIV, REM): operands are converted to magnitudes, then divided unsigned.
- Quotient is negated when the operand signs differ. Remainder takes the sign of the dividend.
- Each iteration: shift {rem, quo} left by 1; trial subtract the divisor from the partial remainder (DATA_WIDTH+1 bits). If the result is non-negative, keep it and set the quotient LSB to 1.

Special cases (RISC-V spec; the special-case value is what appears on `result_o`):
- Divide by zero: quotient = all ones (-1 for DIV), remainder = dividend.
- Signed overflow, -2^(W-1) / -1: quotient = -2^(W-1), remainder = 0.

Reset:
- Asynchronous assertion forces IDLE, `busy_o`=0, `valid_o`=0, `result_o`=0, counter=0, and clears the internal registers.
- Reset mid-CALC discards the operation with no pulse.

## Timing
- `start_i` is sampled at edge E0.
- `busy_o`=1 from after E0 through edge E(DATA_WIDTH).
- DONE follows edge E(DATA_WIDTH): `valid_o`=1 for exactly one cycle, with `result_o` valid in the same cycle.
- Latency is DATA_WIDTH+1 edges from start to the end of the `valid_o` cycle: `valid_o` goes high after E(DATA_WIDTH) and falls at E(DATA_WIDTH+1).
- Back-to-back: `start_i` in the DONE cycle re-enters CALC at the next edge, so there are no dead cycles.
- `busy_o` and `valid_o` are never high together.
- All outputs are registered; none is combinational from an input.

## Configuration
- `DIV_FAST_SPECIAL_EN` defined:
  - Divide-by-zero and signed-overflow are detected from the sampled operands at E0.
  - The block goes straight to DONE, so `valid_o` is high in the cycle after E0.
  - `busy_o` never asserts for these operations.
- `DIV_FAST_SPECIAL_EN` undefined:
  - Special cases run the full DATA_WIDTH iterations.
  - The special-case value overrides the computed value when the result is written at the CALC→DONE transition.
  - Timing is identical to normal operations.
- Result values are identical in both builds.

## Test plan
- DIVU 100/7 and REMU 100/7 → 14 and 2. `busy_o` high for 32 cycles, `valid_o` pulse after edge E32.
- DIV -7/2 → 0xFFFFFFFD (-3); REM -7/2 → 0xFFFFFFFF (-1); REM 7/-2 → 1.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0. DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5. With the macro, `valid_o` comes 1 cycle after start; without it, 32 cycles + 1.
- Back-to-back: start DIVU 9/3, then assert `start_i` in the DONE cycle with REMU 9/4. Results 3 then 1, `busy_o` re-asserts on the next edge, no idle cycle between.
- `flush_i` at iteration 10 of a DIVU → IDLE next edge, no `valid_o`, `result_o` keeps its previous value; a following start completes normally.
- `rstn_i` pulsed low asynchronously mid-CALC → outputs 0 immediately; `start_i` ignored during CALC (second strobe at cycle 5 produces no extra pulse).
